// File: rtl/vic_sched.sv
// vic_sched: edge-triggered interrupt pending/priority arbiter with req/ack handshake
// and a nesting stack so only strictly higher priorities can preempt.
module vic_sched #(
    parameter int N_SRC = 31,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_SRC-1:0] i_ext,
    input  logic [3:0]       i_VIC_data,
    input  logic [4:0]       i_VIC_regaddr,
    input  logic             i_VIC_we,
    input  logic             i_ack,
    input  logic             i_eoi,
    output logic             o_irq,
    output logic [4:0]       o_irq_id,
    output logic [3:0]       o_irq_prio,
    output logic [3:0]       o_depth,
    output logic             o_err
);
    typedef enum logic {S_IDLE, S_REQ} state_t;
    state_t state, state_n;
    logic [3:0]  prio [32];
    logic [4:0]  stk_id [8];
    logic [3:0]  stk_p [8];
    logic [31:0] pend, prev, ext, rise, set, clr, clr_wr, prio_nz;
    logic [3:0]  depth, thr, best_p;
    logic [2:0]  top;
    logic [4:0]  best;
    logic        en, wr_src, wr_ctl, take, pop, issue, withdraw, err_n;

    assign ext    = 32'(i_ext);
    assign rise   = ext & ~prev;
    assign wr_src = i_VIC_we && int'(i_VIC_regaddr) < N_SRC;
    assign wr_ctl = i_VIC_we && &i_VIC_regaddr;
    assign top    = 3'(depth - 4'd1);
    assign thr    = depth == 4'd0 ? 4'd0 : stk_p[top];
    assign take   = state == S_REQ && i_ack;
    assign pop    = i_eoi && depth != 4'd0;
    assign o_irq  = state == S_REQ;
    assign o_depth = depth;

    always_comb begin
        best   = '0;
        best_p = '0;
        // descending scan with >= leaves the lowest index on a priority tie
        for (int i = 31; i >= 0; i--) begin
            prio_nz[i] = |prio[i];
            if (pend[i] && prio[i] > thr && prio[i] >= best_p) begin
                best   = 5'(i);
                best_p = prio[i];
            end
        end
        clr_wr = '0;
        if (wr_src && i_VIC_data == 4'd0) clr_wr[i_VIC_regaddr] = 1'b1;
        if (wr_ctl && i_VIC_data[1]) clr_wr = '1;
        clr = clr_wr;
        if (take) clr[o_irq_id] = 1'b1;
        set      = rise & prio_nz;
        withdraw = (clr_wr[o_irq_id] && !set[o_irq_id]) || (wr_ctl && !i_VIC_data[0]);
        issue    = state == S_IDLE && en && best_p != 4'd0 && depth < 4'(DEPTH);
        state_n  = issue ? S_REQ : (state == S_REQ && (i_ack || withdraw)) ? S_IDLE : state;
        err_n    = (i_eoi && depth == 4'd0) || (i_ack && state == S_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_IDLE;
            pend       <= '0;
            prev       <= '0;
            en         <= 1'b0;
            depth      <= '0;
            o_irq_id   <= '0;
            o_irq_prio <= '0;
            o_err      <= 1'b0;
            for (int i = 0; i < 32; i++) prio[i] <= '0;
        end else begin
            state <= state_n;
            prev  <= ext;
            pend  <= (pend & ~clr) | set;
            depth <= depth + 4'(take) - 4'(pop);
            o_err <= err_n;
            if (wr_ctl) en <= i_VIC_data[0];
            if (wr_src) prio[i_VIC_regaddr] <= i_VIC_data;
            if (issue) begin
                o_irq_id   <= best;
                o_irq_prio <= best_p;
            end
        end
    end

    // a simultaneous eoi+ack overwrites the popped top instead of growing the stack
    always_ff @(posedge i_clk) begin
        if (!i_rst && take) begin
            stk_id[pop ? top : depth[2:0]] <= o_irq_id;
            stk_p[pop ? top : depth[2:0]]  <= o_irq_prio;
        end
    end
endmodule
